// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and word constants for the instruction fetch slice
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int WORD_BYTES  = 4;
  localparam int WORD_W      = 32;
  localparam int INST_ADDR_W = 9;

  // A fetch target must sit on a word boundary.
  function automatic logic misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - fetch controller bus: ROM byte port, decode handshake, redirect
// Ports (master = fetch controller):
//   run                                 fetch enable
//   mem_addr, mem_rd_en / mem_byte      ROM byte read request / data one cycle later
//   inst, inst_pc, inst_valid / inst_ready   word to decode over valid/ready
//   redirect_valid, redirect_target     one-cycle flush to a new fetch address
//   align_err                           pulse for a misaligned redirect target
interface inst_fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
);
  logic              run;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_byte;
  logic [WORD_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              align_err;

  modport master (
    input  run, mem_byte, inst_ready, redirect_valid, redirect_target,
    output mem_addr, mem_rd_en, inst, inst_pc, inst_valid, align_err
  );

  modport slave (
    output run, mem_byte, inst_ready, redirect_valid, redirect_target,
    input  mem_addr, mem_rd_en, inst, inst_pc, inst_valid, align_err
  );
endinterface

// File: rtl/inst_byte_pack.sv
// rtl/inst_byte_pack.sv - four byte slots assembled big-endian into one instruction word
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clear               discard all slots (flush)
//   wr_en, wr_slot      write wr_byte into slot wr_slot (slot 0 is the MSB)
//   wr_byte             byte to store
//   word                {slot0,slot1,slot2,slot3}, including this cycle's write
module inst_byte_pack
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [1:0]        wr_slot,
  input  logic [7:0]        wr_byte,
  output logic [WORD_W-1:0] word
);

  logic [7:0] slots [WORD_BYTES];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < WORD_BYTES; i++) slots[i] <= '0;
    end else if (wr_en) begin
      slots[wr_slot] <= wr_byte;
    end
  end

  // The byte being written is bypassed into the word so the last byte of an
  // instruction can be latched by the controller in the same cycle it arrives.
  always_comb begin
    word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      word[WORD_W-1-8*i -: 8] = (wr_en && (wr_slot == 2'(i))) ? wr_byte : slots[i];
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - fetch sequencer: four byte reads per instruction, valid/ready to decode
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          inst_fetch_ctrl_if master: ROM byte port, decode handshake, redirect, align_err
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  inst_fetch_ctrl_if.master bus
);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [2:0]        k, k_n;          // 0..3 issue reads, 4 is the capture-only cycle
  logic [WORD_W-1:0] inst_q;
  logic [WORD_W-1:0] pack_word;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_valid_q;
  logic              align_err_q;
  logic              handshake;
  logic              capture;
  logic              load_inst;

  assign handshake = inst_valid_q && bus.inst_ready;

  // A byte returns one cycle after its read, so k=1..4 captures slot k-1.
  // The byte returning in the first cycle after a redirect lands at k=0 and is dropped.
  assign capture = (state == FETCH) && (k != 3'd0) && !bus.redirect_valid;

  assign bus.mem_rd_en  = (state == FETCH) && !k[2];
  assign bus.mem_addr   = pc + ADDR_W'(k[1:0]);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.align_err  = align_err_q;

  inst_byte_pack u_pack (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.redirect_valid),
    .wr_en   (capture),
    .wr_slot (2'(k - 3'd1)),
    .wr_byte (bus.mem_byte),
    .word    (pack_word)
  );

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    k_n       = k;
    load_inst = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run) begin
          state_n = FETCH;
          k_n     = 3'd0;
        end
      end
      FETCH: begin
        if (k == 3'd4) begin
          state_n   = HOLD;
          k_n       = 3'd0;
          load_inst = 1'b1;
        end else begin
          k_n = k + 3'd1;
        end
      end
      HOLD: begin
        if (handshake) begin
          pc_n    = pc + ADDR_W'(WORD_BYTES);
          state_n = bus.run ? FETCH : IDLE;
          k_n     = 3'd0;
        end
      end
      default: begin
        state_n = IDLE;
        k_n     = 3'd0;
      end
    endcase
    // Redirect overrides everything; a simultaneous handshake still retires the
    // current word on the decode side, but the target replaces pc+4.
    if (bus.redirect_valid) begin
      pc_n      = {bus.redirect_target[ADDR_W-1:2], 2'b00};
      state_n   = bus.run ? FETCH : IDLE;
      k_n       = 3'd0;
      load_inst = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      k            <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      k           <= k_n;
      align_err_q <= bus.redirect_valid && misaligned(bus.redirect_target[1:0]);
      if (load_inst) begin
        inst_q       <= pack_word;
        inst_pc_q    <= pc;
        inst_valid_q <= 1'b1;
      end else if (handshake || bus.redirect_valid) begin
        inst_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rom [512];

  always #5 clk = ~clk;

  inst_fetch_ctrl_if #(.ADDR_W(9)) bus ();

  inst_fetch_ctrl #(.ADDR_W(9), .RESET_PC(9'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Byte-wide ROM: data appears the cycle after the read request.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_byte <= rom[bus.mem_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
    chk({tag, "_inst"}, 64'(bus.inst), 64'd0);
    chk({tag, "_inst_pc"}, 64'(bus.inst_pc), 64'd0);
    chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
    chk({tag, "_align_err"}, 64'(bus.align_err), 64'd0);
  endtask

  // Entered at the sample point of C0; leaves at the sample point of C5.
  task automatic fetch_word(input string tag, input logic [8:0] base, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_c%0d_rd_en", tag, i), 64'(bus.mem_rd_en), 64'd1);
      chk($sformatf("%s_c%0d_addr", tag, i), 64'(bus.mem_addr), 64'(base + 9'(i)));
      chk($sformatf("%s_c%0d_valid", tag, i), 64'(bus.inst_valid), 64'd0);
      if (i == 1) chk({tag, "_c1_align_err"}, 64'(bus.align_err), 64'd0);
      tick();
    end
    chk({tag, "_c4_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
    chk({tag, "_c4_valid"}, 64'(bus.inst_valid), 64'd0);
    tick();
    chk({tag, "_c5_valid"}, 64'(bus.inst_valid), 64'd1);
    chk({tag, "_c5_inst"}, 64'(bus.inst), 64'(word));
    chk({tag, "_c5_inst_pc"}, 64'(bus.inst_pc), 64'(base));
    chk({tag, "_c5_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'(i);
    rom[0] = 8'h81; rom[1] = 8'hC3; rom[2] = 8'hE0; rom[3] = 8'h08;
    rom[4] = 8'h11; rom[5] = 8'h22; rom[6] = 8'h33; rom[7] = 8'h44;
    rom[100] = 8'hA0; rom[101] = 8'hA1; rom[102] = 8'hA2; rom[103] = 8'hA3;
    rom[200] = 8'hC8; rom[201] = 8'hC9; rom[202] = 8'hCA; rom[203] = 8'hCB;
    rom[508] = 8'hDE; rom[509] = 8'hAD; rom[510] = 8'hBE; rom[511] = 8'hEF;

    reset = 1'b1;
    bus.run = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    tick();
    tick();
    chk_reset_values("reset");

    // First fetch from RESET_PC
    reset = 1'b0;
    bus.run = 1'b1;
    tick();
    fetch_word("first", 9'd0, 32'h81C3E008);

    // Backpressure: word held, no reads
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), 64'(bus.inst_valid), 64'd1);
      chk($sformatf("bp%0d_inst", i), 64'(bus.inst), 64'h81C3E008);
      chk($sformatf("bp%0d_rd_en", i), 64'(bus.mem_rd_en), 64'd0);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("hs_valid_drop", 64'(bus.inst_valid), 64'd0);
    chk("next_c0_addr", 64'(bus.mem_addr), 64'd4);
    chk("next_c0_rd_en", 64'(bus.mem_rd_en), 64'd1);
    tick();
    chk("next_c1_addr", 64'(bus.mem_addr), 64'd5);
    tick();
    chk("next_c2_addr", 64'(bus.mem_addr), 64'd6);

    // Redirect mid-fetch at C2
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 9'd100;
    tick();
    bus.redirect_valid = 1'b0;
    fetch_word("redir100", 9'd100, 32'hA0A1A2A3);

    // Redirect in HOLD without handshake drops the word; fetch from 508
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 9'd508;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir508_valid_drop", 64'(bus.inst_valid), 64'd0);
    fetch_word("w508", 9'd508, 32'hDEADBEEF);

    // Handshake at pc=508 wraps to 0
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    fetch_word("wrap", 9'd0, 32'h81C3E008);

    // Redirect to a misaligned target in the handshake cycle
    chk("hs_redir_pre_valid", 64'(bus.inst_valid), 64'd1);
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 9'd203;
    tick();
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("hs_redir_align_err", 64'(bus.align_err), 64'd1);
    fetch_word("w200", 9'd200, 32'hC8C9CACB);

    // Reset while holding a word at pc=200
    reset = 1'b1;
    tick();
    chk_reset_values("hold_reset");
    reset = 1'b0;
    bus.run = 1'b0;
    tick();
    chk("idle_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("idle_pc", 64'(bus.mem_addr), 64'd0);

    // Redirect in IDLE with run=0: pc moves, stays idle
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 9'd41;
    tick();
    bus.redirect_valid = 1'b0;
    chk("idle_redir_align_err", 64'(bus.align_err), 64'd1);
    chk("idle_redir_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("idle_redir_addr", 64'(bus.mem_addr), 64'd40);
    tick();
    chk("idle_redir_align_err_once", 64'(bus.align_err), 64'd0);
    chk("idle_redir_still_idle", 64'(bus.mem_rd_en), 64'd0);
    bus.run = 1'b1;
    tick();
    fetch_word("w40", 9'd40, 32'h28292A2B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
